memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline; the consumer end of the EX_MEM_* pipeline register.
//  Issues lw/sw to the data memory over a req/ack handshake.
//  Raises mem_stall_c while an access is outstanding; EX holds EX_MEM_* while mem_stall_c=1.
//  Registers MEM_WB_* for writeback and for EX forwarding.
// PARAMETERS
//  MAX_WAIT  64  cycles with dmem_req=1 and no dmem_ack before timeout error (>=1)
// PORTS
//  clock               in   1              single clock, posedge
//  reset_n             in   1              asynchronous, active-low reset
//  EX_MEM_valid        in   1              EX_MEM holds a live instruction
//  EX_MEM_op           in   6              opcode (`lw/`sw/`add/`ori/`lui/`j_inst from defines.vh)
//  EX_MEM_instruc_type in   2              passed through
//  EX_MEM_dest         in   5              destination register
//  EX_MEM_result       in   `DATA_SIZE     ALU result or byte address for lw/sw
//  EX_MEM_B            in   `DATA_SIZE     sw store data
//  EX_MEM_targetPC     in   `ADDRESS_SIZE  next/jump PC
//  dmem_ack            in   1              memory completes access this cycle
//  dmem_rdata          in   `DATA_SIZE     load data, valid when dmem_ack=1
//  dmem_req            out  1              access request
//  dmem_we             out  1              1=store, 0=load
//  dmem_addr           out  `ADDRESS_SIZE  = EX_MEM_result
//  dmem_wdata          out  `DATA_SIZE     = EX_MEM_B
//  mem_stall_c         out  1              combinational stall to EX
//  MEM_WB_valid        out  1              register write pending
//  MEM_WB_dest         out  5              destination register
//  MEM_WB_result       out  `DATA_SIZE     writeback value
//  MEM_WB_op           out  6              opcode passed through
//  MEM_WB_targetPC     out  `ADDRESS_SIZE  PC passed through
//  mem_err             out  1              sticky error: timeout or misaligned access
// BEHAVIOUR
//  Definitions:
//  - memop = EX_MEM_valid & (op==`lw | op==`sw)
//  - mis   = memop & EX_MEM_result[1:0]!=0
//  FSM states IDLE, WAIT, ERR. Async reset -> IDLE, wait_cnt=0, mem_err=0, all MEM_WB_* = 0.
//  dmem_req:
//  - = memop & !mis & state!=ERR; combinational, forced 0 while reset_n=0.
//  - dmem_we/addr/wdata are stable while dmem_req=1.
//  mem_stall_c = (dmem_req & !dmem_ack) | state==ERR.
//  Transitions:
//  - IDLE -> WAIT on dmem_req & !dmem_ack.
//  - WAIT -> IDLE on dmem_ack.
//  - IDLE/WAIT -> ERR when wait_cnt reaches MAX_WAIT-1 with no ack; sets mem_err.
//  - ERR is terminal until reset; it stalls forever.
//  wait_cnt: +1 each cycle in WAIT without ack; cleared on ack or on leaving WAIT.
//  Zero-wait memory (ack in the request cycle) gives no stall: 1 instruction per cycle.
//  MEM_WB update, every edge with mem_stall_c=0:
//  - MEM_WB_result = (op==`lw) ? dmem_rdata : EX_MEM_result.
//  - MEM_WB_valid = EX_MEM_valid & op!=`sw & op!=`j_inst & !mis.
//  - dest, op and targetPC are copied from EX_MEM_*.
//  - While mem_stall_c=1, MEM_WB_* hold; an idempotent rewrite in WB is acceptable.
//  Misaligned lw/sw:
//  - No dmem_req; completes in 1 cycle with MEM_WB_valid=0.
//  - Sets mem_err; the FSM stays in IDLE so the pipeline continues.
//  dmem_ack while dmem_req=0 is ignored.
//  Reset mid-access: dmem_req drops asynchronously, the FSM returns to IDLE, and no MEM_WB update occurs.
// STRUCTURE
//  pipe_pkg: typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_t.
//  Opcodes stay in defines.vh.
//  One sub-module, mem_req_fsm: state register, wait_cnt, dmem_req/mem_stall_c/mem_err.
//  Datapath muxes and MEM_WB registers sit in the top level.
// TESTING
//  - add, valid, result=0x1234, dest=5 -> next edge MEM_WB_valid=1, dest=5, result=0x1234; no dmem_req.
//  - lw, addr=0x40, ack same cycle, rdata=0xDEADBEEF -> mem_stall_c never 1; MEM_WB_result=0xDEADBEEF.
//  - sw, addr=0x44, B=0xCAFE, ack after 3 cycles -> we=1, wdata=0xCAFE;
//    stall=1 for 3 cycles; then MEM_WB_valid=0.
//  - lw with no ack, MAX_WAIT=4 -> ERR after 4 req cycles; mem_err=1; stall stays 1 until reset.
//  - lw, addr=0x42 -> no dmem_req, mem_err=1, MEM_WB_valid=0; next add proceeds normally.
//  - Reset asserted in WAIT cycle 2 -> dmem_req=0 immediately, all outputs 0;
//    after release a new lw completes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stages: widths, opcodes
// and the MEM-stage request FSM state type.
package pipe_pkg;

    localparam int DATA_SIZE    = 32;
    localparam int ADDRESS_SIZE = 32;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_t;

    function automatic logic is_memop(input logic valid, input logic [5:0] op);
        return valid & ((op == OP_LW) | (op == OP_SW));
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: tracks an outstanding access, counts wait
// cycles, and flags timeout or misalignment as a sticky error.
module mem_req_fsm
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic memop_i,
    input  logic mis_i,
    input  logic dmem_ack_i,
    output logic dmem_req_o,
    output logic mem_stall_o,
    output logic mem_err_o
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    mem_state_t       state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Request drops combinationally with reset so memory never sees a stale access.
    assign dmem_req_o  = reset_n & memop_i & ~mis_i & (state_q != ERR);
    assign mem_stall_o = (dmem_req_o & ~dmem_ack_i) | (state_q == ERR);
    assign mem_err_o   = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, WAIT: begin
                    if (dmem_req_o && dmem_ack_i) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else if (dmem_req_o) begin
                        if (wait_cnt_q == LAST) begin
                            state_q    <= ERR;
                            wait_cnt_q <= '0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q    <= WAIT;
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end else begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end
                    if (mis_i) begin
                        err_q <= 1'b1;
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues lw/sw over a req/ack
// handshake, stalls EX while an access is outstanding, and registers MEM_WB.
module memory_stage
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    EX_MEM_valid,
    input  logic [5:0]              EX_MEM_op,
    input  logic [1:0]              EX_MEM_instruc_type,
    input  logic [4:0]              EX_MEM_dest,
    input  logic [DATA_SIZE-1:0]    EX_MEM_result,
    input  logic [DATA_SIZE-1:0]    EX_MEM_B,
    input  logic [ADDRESS_SIZE-1:0] EX_MEM_targetPC,
    input  logic                    dmem_ack,
    input  logic [DATA_SIZE-1:0]    dmem_rdata,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDRESS_SIZE-1:0] dmem_addr,
    output logic [DATA_SIZE-1:0]    dmem_wdata,
    output logic                    mem_stall_c,
    output logic                    MEM_WB_valid,
    output logic [4:0]              MEM_WB_dest,
    output logic [DATA_SIZE-1:0]    MEM_WB_result,
    output logic [5:0]              MEM_WB_op,
    output logic [ADDRESS_SIZE-1:0] MEM_WB_targetPC,
    output logic                    mem_err
);

    logic                    memop;
    logic                    mis;
    logic                    wb_valid_d, wb_valid_q;
    logic [4:0]              wb_dest_d, wb_dest_q;
    logic [DATA_SIZE-1:0]    wb_result_d, wb_result_q;
    logic [5:0]              wb_op_d, wb_op_q;
    logic [ADDRESS_SIZE-1:0] wb_pc_d, wb_pc_q;

    // Instruction type has no consumer past EX_MEM in this stage.
    logic unused_instruc_type;
    assign unused_instruc_type = ^EX_MEM_instruc_type;

    mem_req_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clock       (clock),
        .reset_n     (reset_n),
        .memop_i     (memop),
        .mis_i       (mis),
        .dmem_ack_i  (dmem_ack),
        .dmem_req_o  (dmem_req),
        .mem_stall_o (mem_stall_c),
        .mem_err_o   (mem_err)
    );

    // Address/data come straight from EX_MEM, which EX holds during a stall.
    assign dmem_we    = reset_n & (EX_MEM_op == OP_SW);
    assign dmem_addr  = reset_n ? EX_MEM_result : '0;
    assign dmem_wdata = reset_n ? EX_MEM_B : '0;

    always_comb begin
        memop       = is_memop(EX_MEM_valid, EX_MEM_op);
        mis         = memop & (EX_MEM_result[1:0] != 2'b00);
        wb_result_d = (EX_MEM_op == OP_LW) ? dmem_rdata : EX_MEM_result;
        wb_valid_d  = EX_MEM_valid & (EX_MEM_op != OP_SW) & (EX_MEM_op != OP_J) & ~mis;
        wb_dest_d   = EX_MEM_dest;
        wb_op_d     = EX_MEM_op;
        wb_pc_d     = EX_MEM_targetPC;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
            wb_result_q <= '0;
            wb_op_q     <= '0;
            wb_pc_q     <= '0;
        end else if (!mem_stall_c) begin
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
            wb_result_q <= wb_result_d;
            wb_op_q     <= wb_op_d;
            wb_pc_q     <= wb_pc_d;
        end
    end

    assign MEM_WB_valid    = wb_valid_q;
    assign MEM_WB_dest     = wb_dest_q;
    assign MEM_WB_result   = wb_result_q;
    assign MEM_WB_op       = wb_op_q;
    assign MEM_WB_targetPC = wb_pc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized and directed bench for memory_stage, checked against a
// transaction-level model of the MEM-stage rules (latency, errors, writeback).
module tb_memory_stage;
    import pipe_pkg::*;

    localparam int MAXW  = 4;
    localparam int BOUND = 12;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        EX_MEM_valid = 1'b0;
    logic [5:0]  EX_MEM_op = '0;
    logic [1:0]  EX_MEM_instruc_type = '0;
    logic [4:0]  EX_MEM_dest = '0;
    logic [31:0] EX_MEM_result = '0;
    logic [31:0] EX_MEM_B = '0;
    logic [31:0] EX_MEM_targetPC = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req, dmem_we, mem_stall_c, MEM_WB_valid, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, MEM_WB_result, MEM_WB_targetPC;
    logic [4:0]  MEM_WB_dest;
    logic [5:0]  MEM_WB_op;

    int   total = 0;
    int   bad = 0;
    logic model_err = 1'b0;

    always #5 clock = ~clock;

    memory_stage #(.MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset_n(reset_n),
        .EX_MEM_valid(EX_MEM_valid), .EX_MEM_op(EX_MEM_op),
        .EX_MEM_instruc_type(EX_MEM_instruc_type), .EX_MEM_dest(EX_MEM_dest),
        .EX_MEM_result(EX_MEM_result), .EX_MEM_B(EX_MEM_B),
        .EX_MEM_targetPC(EX_MEM_targetPC), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .mem_stall_c(mem_stall_c),
        .MEM_WB_valid(MEM_WB_valid), .MEM_WB_dest(MEM_WB_dest),
        .MEM_WB_result(MEM_WB_result), .MEM_WB_op(MEM_WB_op),
        .MEM_WB_targetPC(MEM_WB_targetPC), .mem_err(mem_err)
    );

    // Drive one instruction until it leaves MEM (or BOUND stalled cycles pass);
    // memory acks `lat` cycles after the request first appears.
    task automatic issue(input logic v, input logic [5:0] op, input logic [31:0] res,
                         input logic [31:0] b, input logic [4:0] dest, input logic [31:0] pc,
                         input logic [31:0] rd, input int lat,
                         output int req_cnt, output int stalls, output logic we_o,
                         output logic [31:0] addr_o, output logic [31:0] wdata_o,
                         output logic stable, output logic hold_ok);
        logic        st, s_v;
        logic [4:0]  s_d;
        logic [5:0]  s_op;
        logic [31:0] s_res, s_pc;
        int          k;
        req_cnt = 0; stalls = 0; we_o = 0; addr_o = 0; wdata_o = 0;
        stable = 1; hold_ok = 1; k = 0;
        @(negedge clock);
        EX_MEM_valid = v; EX_MEM_op = op; EX_MEM_result = res; EX_MEM_B = b;
        EX_MEM_dest = dest; EX_MEM_targetPC = pc;
        EX_MEM_instruc_type = 2'($urandom);
        dmem_ack = (lat == 0);
        dmem_rdata = (lat == 0) ? rd : $urandom;
        forever begin
            #1;
            st = mem_stall_c;
            if (dmem_req) begin
                if (req_cnt == 0) begin
                    we_o = dmem_we; addr_o = dmem_addr; wdata_o = dmem_wdata;
                end else if (dmem_we !== we_o || dmem_addr !== addr_o || dmem_wdata !== wdata_o) begin
                    stable = 0;
                end
                req_cnt++;
            end
            s_v = MEM_WB_valid; s_d = MEM_WB_dest; s_op = MEM_WB_op;
            s_res = MEM_WB_result; s_pc = MEM_WB_targetPC;
            @(posedge clock);
            #1;
            if (!st) break;
            if (MEM_WB_valid !== s_v || MEM_WB_dest !== s_d || MEM_WB_op !== s_op ||
                MEM_WB_result !== s_res || MEM_WB_targetPC !== s_pc)
                hold_ok = 0;
            stalls++;
            k++;
            if (k >= BOUND) break;
            @(negedge clock);
            dmem_ack = (k == lat);
            dmem_rdata = (k == lat) ? rd : $urandom;
        end
        EX_MEM_valid = 0;
        dmem_ack = 0;
    endtask

    // Transaction-level expectation: request cycles, stall cycles and writeback.
    task automatic model(input logic v, input logic [5:0] op, input logic [31:0] res,
                         input logic [31:0] rd, input int lat,
                         output int e_req, output int e_stalls, output logic e_wbv,
                         output logic [31:0] e_res, output logic e_mis, output logic e_to);
        logic is_mem;
        is_mem = v && (op == OP_LW || op == OP_SW);
        e_mis  = is_mem && (res[1:0] != 2'b00);
        e_to   = 0; e_req = 0; e_stalls = 0;
        if (is_mem && !e_mis) begin
            if (lat <= MAXW - 1) begin
                e_req = lat + 1; e_stalls = lat;
            end else begin
                e_req = MAXW; e_stalls = BOUND; e_to = 1;
            end
        end
        e_wbv = v && op != OP_SW && op != OP_J && !e_mis;
        e_res = (op == OP_LW) ? rd : res;
    endtask

    task automatic test_reset();
        EX_MEM_valid = 1; EX_MEM_op = OP_LW; EX_MEM_result = 32'h40;
        #1 reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem_req); end
        total++; if (mem_stall_c !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", mem_stall_c); end
        total++; if (MEM_WB_valid !== 1'b0 || MEM_WB_result !== 32'h0 || MEM_WB_dest !== 5'h0)
            begin bad++; $display("FAIL reset_wb got=%b/%h/%h want=0/0/0", MEM_WB_valid, MEM_WB_result, MEM_WB_dest); end
        total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", mem_err); end
        @(negedge clock);
        EX_MEM_valid = 0;
        reset_n = 1;
        model_err = 0;
    endtask

    task automatic test_alu();
        int rq, st; logic we, sb, ho; logic [31:0] ad, wd;
        issue(1, OP_ADD, 32'h1234, 32'h0, 5'd5, 32'h100, 32'h0, 0, rq, st, we, ad, wd, sb, ho);
        total++; if (rq !== 0) begin bad++; $display("FAIL alu_req got=%0d want=0", rq); end
        total++; if (MEM_WB_valid !== 1'b1 || MEM_WB_dest !== 5'd5 || MEM_WB_result !== 32'h1234)
            begin bad++; $display("FAIL alu_wb got=%b/%0d/%h want=1/5/1234", MEM_WB_valid, MEM_WB_dest, MEM_WB_result); end
    endtask

    task automatic test_lw_zero_wait();
        int rq, st; logic we, sb, ho; logic [31:0] ad, wd;
        issue(1, OP_LW, 32'h40, 32'h0, 5'd9, 32'h104, 32'hDEADBEEF, 0, rq, st, we, ad, wd, sb, ho);
        total++; if (st !== 0 || rq !== 1) begin bad++; $display("FAIL lw0_stall stalls=%0d req=%0d want=0/1", st, rq); end
        total++; if (we !== 1'b0 || ad !== 32'h40) begin bad++; $display("FAIL lw0_bus we=%b addr=%h want=0/40", we, ad); end
        total++; if (MEM_WB_valid !== 1'b1 || MEM_WB_result !== 32'hDEADBEEF)
            begin bad++; $display("FAIL lw0_wb got=%b/%h want=1/deadbeef", MEM_WB_valid, MEM_WB_result); end
    endtask

    task automatic test_sw_wait();
        int rq, st; logic we, sb, ho; logic [31:0] ad, wd;
        issue(1, OP_SW, 32'h44, 32'hCAFE, 5'd3, 32'h108, 32'h0, 3, rq, st, we, ad, wd, sb, ho);
        total++; if (we !== 1'b1 || ad !== 32'h44 || wd !== 32'hCAFE)
            begin bad++; $display("FAIL sw_bus we=%b addr=%h wdata=%h want=1/44/cafe", we, ad, wd); end
        total++; if (st !== 3 || rq !== 4) begin bad++; $display("FAIL sw_stall stalls=%0d req=%0d want=3/4", st, rq); end
        total++; if (sb !== 1'b1 || ho !== 1'b1) begin bad++; $display("FAIL sw_hold stable=%b hold=%b want=1/1", sb, ho); end
        total++; if (MEM_WB_valid !== 1'b0 || mem_err !== 1'b0)
            begin bad++; $display("FAIL sw_wb valid=%b err=%b want=0/0", MEM_WB_valid, mem_err); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [6];
        logic        v, e_wbv, e_mis, e_to, we, sb, ho;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic [31:0] res, b, pc, rd, e_res, ad, wd;
        int          lat, rq, st, e_req, e_st;
        ops = '{OP_LW, OP_SW, OP_ADD, OP_ORI, OP_LUI, OP_J};
        for (int n = 0; n < 60; n++) begin
            v = ($urandom_range(0, 7) != 0);
            op = ops[$urandom_range(0, 5)];
            res = $urandom;
            if ($urandom_range(0, 11) != 0) res[1:0] = 2'b00;
            b = $urandom; dest = 5'($urandom); pc = $urandom; rd = $urandom;
            lat = $urandom_range(0, MAXW - 1);
            model(v, op, res, rd, lat, e_req, e_st, e_wbv, e_res, e_mis, e_to);
            model_err = model_err | e_mis | e_to;
            issue(v, op, res, b, dest, pc, rd, lat, rq, st, we, ad, wd, sb, ho);
            total++; if (rq !== e_req || st !== e_st)
                begin bad++; $display("FAIL rand%0d_timing req=%0d stalls=%0d want=%0d/%0d", n, rq, st, e_req, e_st); end
            if (e_req > 0) begin
                total++; if (we !== (op == OP_SW) || ad !== res || wd !== b || sb !== 1'b1)
                    begin bad++; $display("FAIL rand%0d_bus we=%b addr=%h wdata=%h stable=%b want=%b/%h/%h/1", n, we, ad, wd, sb, op == OP_SW, res, b); end
                total++; if (ho !== 1'b1) begin bad++; $display("FAIL rand%0d_hold got=%b want=1", n, ho); end
            end
            total++; if (MEM_WB_valid !== e_wbv || MEM_WB_dest !== dest || MEM_WB_op !== op || MEM_WB_targetPC !== pc)
                begin bad++; $display("FAIL rand%0d_wb v=%b d=%0d op=%h pc=%h want=%b/%0d/%h/%h", n, MEM_WB_valid, MEM_WB_dest, MEM_WB_op, MEM_WB_targetPC, e_wbv, dest, op, pc); end
            if (e_wbv) begin
                total++; if (MEM_WB_result !== e_res)
                    begin bad++; $display("FAIL rand%0d_result got=%h want=%h", n, MEM_WB_result, e_res); end
            end
            total++; if (mem_err !== model_err) begin bad++; $display("FAIL rand%0d_err got=%b want=%b", n, mem_err, model_err); end
        end
    endtask

    task automatic test_misaligned();
        int rq, st; logic we, sb, ho; logic [31:0] ad, wd;
        issue(1, OP_LW, 32'h42, 32'h0, 5'd4, 32'h200, 32'h1111, 0, rq, st, we, ad, wd, sb, ho);
        total++; if (rq !== 0 || st !== 0) begin bad++; $display("FAIL mis_req req=%0d stalls=%0d want=0/0", rq, st); end
        total++; if (mem_err !== 1'b1 || MEM_WB_valid !== 1'b0)
            begin bad++; $display("FAIL mis_wb err=%b valid=%b want=1/0", mem_err, MEM_WB_valid); end
        issue(1, OP_ADD, 32'h55, 32'h0, 5'd7, 32'h204, 32'h0, 0, rq, st, we, ad, wd, sb, ho);
        total++; if (st !== 0 || MEM_WB_valid !== 1'b1 || MEM_WB_dest !== 5'd7 || MEM_WB_result !== 32'h55)
            begin bad++; $display("FAIL mis_next stalls=%0d wb=%b/%0d/%h want=0/1/7/55", st, MEM_WB_valid, MEM_WB_dest, MEM_WB_result); end
    endtask

    task automatic test_reset_mid_access();
        int rq, st; logic we, sb, ho; logic [31:0] ad, wd;
        @(negedge clock);
        EX_MEM_valid = 1; EX_MEM_op = OP_LW; EX_MEM_result = 32'h80; EX_MEM_dest = 5'd6; dmem_ack = 0;
        @(negedge clock);
        #2 reset_n = 0;
        #1;
        total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || mem_stall_c !== 1'b0)
            begin bad++; $display("FAIL rstmid_bus req=%b we=%b addr=%h stall=%b want=0/0/0/0", dmem_req, dmem_we, dmem_addr, mem_stall_c); end
        total++; if (MEM_WB_valid !== 1'b0 || MEM_WB_result !== 32'h0 || mem_err !== 1'b0)
            begin bad++; $display("FAIL rstmid_wb valid=%b result=%h err=%b want=0/0/0", MEM_WB_valid, MEM_WB_result, mem_err); end
        @(negedge clock);
        EX_MEM_valid = 0;
        reset_n = 1;
        model_err = 0;
        issue(1, OP_LW, 32'h80, 32'h0, 5'd6, 32'h300, 32'h0BADF00D, 1, rq, st, we, ad, wd, sb, ho);
        total++; if (st !== 1 || MEM_WB_valid !== 1'b1 || MEM_WB_result !== 32'h0BADF00D)
            begin bad++; $display("FAIL rstmid_after stalls=%0d wb=%b/%h want=1/1/0badf00d", st, MEM_WB_valid, MEM_WB_result); end
    endtask

    task automatic test_timeout();
        int rq, st; logic we, sb, ho; logic [31:0] ad, wd;
        issue(1, OP_LW, 32'h100, 32'h0, 5'd8, 32'h400, 32'h0, 100, rq, st, we, ad, wd, sb, ho);
        total++; if (rq !== MAXW || st !== BOUND)
            begin bad++; $display("FAIL to_timing req=%0d stalls=%0d want=%0d/%0d", rq, st, MAXW, BOUND); end
        total++; if (mem_err !== 1'b1 || ho !== 1'b1) begin bad++; $display("FAIL to_err err=%b hold=%b want=1/1", mem_err, ho); end
        repeat (3) @(posedge clock);
        #1;
        total++; if (mem_stall_c !== 1'b1 || dmem_req !== 1'b0)
            begin bad++; $display("FAIL to_sticky stall=%b req=%b want=1/0", mem_stall_c, dmem_req); end
        reset_n = 0;
        #1;
        total++; if (mem_stall_c !== 1'b0 || mem_err !== 1'b0)
            begin bad++; $display("FAIL to_reset stall=%b err=%b want=0/0", mem_stall_c, mem_err); end
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_lw_zero_wait();
        test_sw_wait();
        test_random();
        test_misaligned();
        test_reset_mid_access();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
